prog_loader: RTL and testbench

- Upstream feeder for the program ROM. Takes a byte stream from the serial receiver and frames it as a 16-bit word count followed by the instruction words.
- Assembles each word little-endian and drives the ROM programming interface (prog, p_avail, p_d_in, p_ready, p_lo_ack) with a four-phase handshake.
- Detects bad length, overflow and stalled streams, and aborts cleanly on any of them.

---
 rtl/prog_loader.sv | 146 ++++++++++++++
 tb/tb_prog_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: frames a byte stream (16-bit count + little-endian words) and
// writes the words to the program ROM through a four-phase handshake.
module prog_loader #(
    parameter int WORD_W         = 32,
    parameter int ROM_DEPTH      = 256,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              prog,
    output logic              p_avail,
    output logic [WORD_W-1:0] p_d_in,
    input  logic              p_ready,
    input  logic              p_lo_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam int NB   = WORD_W / 8;
    localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {LEN0, LEN1, DATA, DRAIN} rx_st_t;
    typedef enum logic [1:0] {HS_IDLE, HS_AVAIL, HS_ACK} hs_st_t;

    rx_st_t            r_rx_st, w_rx_nxt;
    hs_st_t            r_hs_st, w_hs_nxt;
    logic [7:0]        r_lo;
    logic [15:0]       r_len, r_words_rx, r_words_sent;
    logic [BI_W-1:0]   r_bidx;
    logic [WORD_W-1:0] r_asm, r_hold, r_p_d_in, w_word;
    logic              r_hold_full, r_prog_d, r_done, r_err;
    logic [1:0]        r_err_code, w_code;
    logic [TC_W-1:0]   r_tcnt;
    logic [15:0]       w_len;
    logic              w_byte, w_last, w_len_err, w_len_zero, w_ovf, w_counting;
    logic              w_tmo, w_abort, w_push, w_pop, w_complete, w_hs_go;

    always_comb begin
        w_len      = {rx_data, r_lo};
        w_byte     = r_rx_st == DATA && rx_valid;
        w_last     = w_byte && r_bidx == BI_W'(NB - 1);
        w_len_err  = r_rx_st == LEN1 && rx_valid && w_len > 16'(ROM_DEPTH);
        w_len_zero = r_rx_st == LEN1 && rx_valid && w_len == 16'd0;
        w_ovf      = w_last && r_hold_full;
        w_counting = r_rx_st == LEN1 || r_rx_st == DATA;
        w_tmo      = w_counting && !rx_valid && r_tcnt == TC_W'(TIMEOUT_CYCLES - 1);
        w_abort    = w_len_err || w_ovf || w_tmo;
        w_code     = w_len_err ? 2'b01 : w_ovf ? 2'b11 : w_tmo ? 2'b10 : 2'b00;
        w_push     = w_last && !r_hold_full;
        w_pop      = r_hs_st == HS_ACK && p_lo_ack;
        w_complete = r_rx_st == DRAIN && r_words_sent == r_len;
        // prog must already have been high a cycle before p_avail may rise
        w_hs_go    = r_hs_st == HS_IDLE && r_hold_full && prog && r_prog_d && !w_abort;
        w_word     = r_asm;
        for (int k = 0; k < NB; k++)
            if (r_bidx == BI_W'(k)) w_word[8*k +: 8] = rx_data;
    end

    always_comb begin
        w_rx_nxt = r_rx_st;
        case (r_rx_st)
            LEN0:  w_rx_nxt = rx_valid ? LEN1 : LEN0;
            LEN1:  w_rx_nxt = (rx_valid && !w_len_zero) ? DATA : (rx_valid || w_tmo) ? LEN0 : LEN1;
            DATA:  w_rx_nxt = (w_push && r_words_rx + 16'd1 == r_len) ? DRAIN : DATA;
            DRAIN: w_rx_nxt = w_complete ? LEN0 : DRAIN;
        endcase
        if (w_abort) w_rx_nxt = LEN0;
        case (r_hs_st)
            HS_IDLE:  w_hs_nxt = w_hs_go ? HS_AVAIL : HS_IDLE;
            HS_AVAIL: w_hs_nxt = p_ready ? HS_ACK : HS_AVAIL;
            HS_ACK:   w_hs_nxt = p_lo_ack ? HS_IDLE : HS_ACK;
            default:  w_hs_nxt = HS_IDLE;
        endcase
        if (w_abort) w_hs_nxt = HS_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_st      <= LEN0;
            r_hs_st      <= HS_IDLE;
            r_lo         <= '0;
            r_len        <= '0;
            r_words_rx   <= '0;
            r_words_sent <= '0;
            r_bidx       <= '0;
            r_asm        <= '0;
            r_hold       <= '0;
            r_p_d_in     <= '0;
            r_hold_full  <= 1'b0;
            r_prog_d     <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 2'b00;
            r_tcnt       <= '0;
        end else begin
            r_rx_st    <= w_rx_nxt;
            r_hs_st    <= w_hs_nxt;
            r_prog_d   <= prog;
            r_done     <= w_len_zero || w_complete;
            r_err      <= w_abort;
            r_err_code <= w_code;
            if (w_abort) begin
                r_len        <= '0;
                r_words_rx   <= '0;
                r_words_sent <= '0;
                r_bidx       <= '0;
                r_tcnt       <= '0;
                r_hold_full  <= 1'b0;
            end else begin
                r_tcnt      <= (w_counting && !rx_valid) ? r_tcnt + 1'b1 : '0;
                r_hold_full <= w_push ? 1'b1 : w_pop ? 1'b0 : r_hold_full;
                if (r_rx_st == LEN0 && rx_valid) r_lo <= rx_data;
                if (r_rx_st == LEN1 && rx_valid) begin
                    r_len        <= w_len;
                    r_words_rx   <= '0;
                    r_words_sent <= '0;
                    r_bidx       <= '0;
                end
                if (w_byte) begin
                    r_asm  <= w_word;
                    r_bidx <= w_last ? '0 : r_bidx + 1'b1;
                end
                if (w_push) begin
                    r_hold     <= w_word;
                    r_words_rx <= r_words_rx + 16'd1;
                end
                if (w_hs_go) r_p_d_in <= r_hold;
                if (w_pop) r_words_sent <= r_words_sent + 16'd1;
            end
        end
    end

    always_comb begin
        prog     = r_rx_st == DATA || r_rx_st == DRAIN;
        p_avail  = r_hs_st == HS_AVAIL;
        p_d_in   = r_p_d_in;
        busy     = r_rx_st != LEN0 || r_hold_full || r_hs_st != HS_IDLE;
        done     = r_done;
        err      = r_err;
        err_code = r_err_code;
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames against prog_loader with a queued
// scoreboard of expected ROM words, done pulses and error codes.
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        rst_n, rx_valid, p_ready, p_lo_ack;
    logic [7:0]  rx_data;
    logic        prog, p_avail, busy, done, err;
    logic [31:0] p_d_in;
    logic [1:0]  err_code;

    typedef struct {logic [1:0] k; logic [31:0] d;} ev_t;
    ev_t sb[$];
    int checks = 0, errors = 0, rom_dly = 2, n_prog_rise = 0, n_avail = 0;
    logic prev_prog = 1'b0, prev_avail = 1'b0;

    always #5 clk = ~clk;

    prog_loader #(.WORD_W(32), .ROM_DEPTH(256), .TIMEOUT_CYCLES(40)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .prog(prog), .p_avail(p_avail), .p_d_in(p_d_in), .p_ready(p_ready),
        .p_lo_ack(p_lo_ack), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // kinds: 0 = ROM word, 1 = done pulse, 2 = error pulse with code
    task automatic expect_ev(input logic [1:0] k, input logic [31:0] d);
        ev_t e;
        e.k = k;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic got(input logic [1:0] k, input logic [31:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected none", k, d);
        end else begin
            e = sb.pop_front();
            check("scoreboard_event", {30'd0, k, d}, {30'd0, e.k, e.d});
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (prog && !prev_prog) n_prog_rise++;
        if (p_avail && !prev_avail) begin
            n_avail++;
            check("prog_before_avail", 64'(prev_prog), 64'd1);
            got(2'd0, p_d_in);
        end
        if (done) got(2'd1, 32'd0);
        if (err) got(2'd2, {30'd0, err_code});
        prev_prog  = prog;
        prev_avail = p_avail;
    end

    // ROM model: p_ready rom_dly cycles after p_avail, then p_lo_ack for one cycle
    initial begin
        p_ready  = 1'b0;
        p_lo_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (p_avail) begin
                repeat (rom_dly) @(negedge clk);
                p_ready = 1'b1;
                while (p_avail) @(negedge clk);
                p_ready  = 1'b0;
                p_lo_ack = 1'b1;
                @(negedge clk);
                p_lo_ack = 1'b0;
            end
        end
    end

    task automatic send_b(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_w(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_b(w[8*k +: 8], gap);
    endtask

    task automatic wait_empty(input string name, input int lim);
        for (int i = 0; i < lim && sb.size() != 0; i++) @(negedge clk);
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_idle(input string name);
        check({name, "_prog"}, 64'(prog), 64'd0);
        check({name, "_avail"}, 64'(p_avail), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int pr;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_done", 64'(done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_code", 64'(err_code), 64'd0);
        check("reset_pdin", 64'(p_d_in), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // three-word image with a slow ROM and gapped bytes
        pr = n_prog_rise;
        expect_ev(0, 32'h11223344);
        expect_ev(0, 32'hDEADBEEF);
        expect_ev(0, 32'h0BADF00D);
        expect_ev(1, 0);
        send_b(8'h03, 2);
        send_b(8'h00, 2);
        send_w(32'h11223344, 2);
        send_w(32'hDEADBEEF, 2);
        send_w(32'h0BADF00D, 2);
        wait_empty("frame3_drain", 200);
        @(negedge clk);
        check_idle("frame3_end");
        check("frame3_prog_rises", 64'(n_prog_rise - pr), 64'd1);

        // zero-length image
        pr = n_prog_rise;
        expect_ev(1, 0);
        send_b(8'h00, 0);
        send_b(8'h00, 0);
        wait_empty("len0_drain", 20);
        check("len0_prog_rises", 64'(n_prog_rise - pr), 64'd0);

        // oversize count, then a valid single-word frame
        expect_ev(2, 32'd1);
        send_b(8'h01, 0);
        send_b(8'h01, 0);
        wait_empty("len257_drain", 20);
        check("len257_prog_rises", 64'(n_prog_rise - pr), 64'd0);
        expect_ev(0, 32'hCAFEF00D);
        expect_ev(1, 0);
        send_b(8'h01, 0);
        send_b(8'h00, 0);
        send_w(32'hCAFEF00D, 2);
        wait_empty("recover_drain", 100);

        // stream stalls after five data bytes
        expect_ev(0, 32'h01020304);
        expect_ev(2, 32'd2);
        send_b(8'h02, 0);
        send_b(8'h00, 0);
        send_w(32'h01020304, 2);
        send_b(8'h55, 0);
        wait_empty("timeout_drain", 200);
        @(negedge clk);
        check_idle("timeout_end");

        // back-to-back bytes with a stalling ROM: second word finds hold full
        rom_dly = 20;
        expect_ev(0, 32'hA1B2C3D4);
        expect_ev(2, 32'd3);
        send_b(8'h02, 0);
        send_b(8'h00, 0);
        send_w(32'hA1B2C3D4, 0);
        send_w(32'h5566_7788, 0);
        wait_empty("ovf_drain", 100);
        repeat (40) @(negedge clk);
        check_idle("ovf_end");

        // same stream, fast ROM
        rom_dly = 0;
        expect_ev(0, 32'hA1B2C3D4);
        expect_ev(0, 32'h55667788);
        expect_ev(1, 0);
        send_b(8'h02, 0);
        send_b(8'h00, 0);
        send_w(32'hA1B2C3D4, 0);
        send_w(32'h5566_7788, 0);
        wait_empty("fast_drain", 100);
        @(negedge clk);
        check_idle("fast_end");

        // asynchronous reset in the middle of a handshake
        rom_dly = 20;
        expect_ev(0, 32'h0F0E0D0C);
        send_b(8'h02, 0);
        send_b(8'h00, 0);
        send_w(32'h0F0E0D0C, 0);
        for (int i = 0; i < 50 && !p_avail; i++) @(negedge clk);
        check("rst_avail_up", 64'(p_avail), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_idle("rst_async");
        check("rst_async_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("rst_release");
        check("rst_release_err", 64'(err), 64'd0);
        repeat (40) @(negedge clk);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
